// File: rtl/ascon_decrypt_core_if.sv
// Stream and status bundle between an ASCON-128 decryption core and its driver.
interface ascon_decrypt_core_if;
  logic         start_i;
  logic [127:0] key_i;
  logic [127:0] nonce_i;
  logic [127:0] tag_i;
  logic [63:0]  data_i;
  logic         data_valid_i;
  logic         ad_i;
  logic         last_i;
  logic         data_ready_o;
  logic [63:0]  plain_o;
  logic         plain_valid_o;
  logic         tag_ok_o;
  logic         done_o;
  logic         busy_o;

  modport master (
    output start_i, key_i, nonce_i, tag_i, data_i, data_valid_i, ad_i, last_i,
    input  data_ready_o, plain_o, plain_valid_o, tag_ok_o, done_o, busy_o
  );

  modport slave (
    input  start_i, key_i, nonce_i, tag_i, data_i, data_valid_i, ad_i, last_i,
    output data_ready_o, plain_o, plain_valid_o, tag_ok_o, done_o, busy_o
  );
endinterface

// File: rtl/ascon_decrypt_core.sv
// ASCON-128 authenticated decryption: one permutation round per cycle,
// self-sequenced through init, AD absorb, ciphertext decrypt and tag check.
module ascon_decrypt_core #(
  parameter int          PA = 12,
  parameter int          PB = 6,
  parameter logic [63:0] IV = 64'h80400c0600000000
) (
  input logic clock_i,
  input logic reset_i,
  ascon_decrypt_core_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    AD_WAIT = 3'd2,
    AD_PERM = 3'd3,
    CT_WAIT = 3'd4,
    CT_PERM = 3'd5,
    FINAL   = 3'd6,
    DONE    = 3'd7
  } state_t;

  localparam logic [3:0] PA_START = 4'(12 - PA);
  localparam logic [3:0] PB_START = 4'(12 - PB);
  localparam logic [3:0] LAST_RND = 4'd11;

  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  // Constant addition, 5-bit substitution layer and linear diffusion layer.
  function automatic logic [4:0][63:0] ascon_round(input logic [4:0][63:0] s, input logic [7:0] rc);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    logic [4:0][63:0] r;
    x0 = s[0];
    x1 = s[1];
    x2 = s[2] ^ {56'd0, rc};
    x3 = s[3];
    x4 = s[4];
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    r[0] = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
    r[1] = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
    r[2] = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
    r[3] = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
    r[4] = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [4:0][63:0] s_q, s_d;
  logic [3:0]       rnd_q, rnd_d;
  logic [127:0]     key_q, key_d;
  logic [127:0]     tag_q, tag_d;
  logic             last_q, last_d;
  logic [63:0]      plain_q, plain_d;
  logic             plain_valid_q, plain_valid_d;
  logic             tag_ok_q, tag_ok_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;

  logic [4:0][63:0] round_s;
  logic             xfer_s;

  // Round constant ((15-r)<<4)|r is simply {~r, r} for a 4-bit index.
  assign round_s = ascon_round(s_q, {~rnd_q, rnd_q});
  assign xfer_s  = bus.data_valid_i & ready_q;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d       = state_q;
    s_d           = s_q;
    rnd_d         = rnd_q;
    key_d         = key_q;
    tag_d         = tag_q;
    last_d        = last_q;
    plain_d       = plain_q;
    plain_valid_d = 1'b0;
    tag_ok_d      = tag_ok_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start_i) begin
          s_d[0]   = IV;
          s_d[1]   = bus.key_i[127:64];
          s_d[2]   = bus.key_i[63:0];
          s_d[3]   = bus.nonce_i[127:64];
          s_d[4]   = bus.nonce_i[63:0];
          key_d    = bus.key_i;
          tag_d    = bus.tag_i;
          tag_ok_d = 1'b0;
          rnd_d    = PA_START;
          state_d  = INIT;
        end
      end
      INIT: begin
        s_d   = round_s;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == LAST_RND) begin
          s_d[3]  = round_s[3] ^ key_q[127:64];
          s_d[4]  = round_s[4] ^ key_q[63:0];
          rnd_d   = 4'd0;
          state_d = AD_WAIT;
        end
      end
      AD_WAIT, CT_WAIT: begin
        if (xfer_s) begin
          rnd_d = PB_START;
          if (bus.ad_i && (state_q == AD_WAIT)) begin
            s_d[0]  = s_q[0] ^ bus.data_i;
            state_d = AD_PERM;
          end else begin
            // First ciphertext straight out of AD_WAIT also applies domain separation.
            if (state_q == AD_WAIT) begin
              s_d[4] = s_q[4] ^ 64'd1;
            end
            plain_d       = s_q[0] ^ bus.data_i;
            s_d[0]        = bus.data_i;
            last_d        = bus.last_i;
            plain_valid_d = 1'b1;
            state_d       = CT_PERM;
          end
        end
      end
      AD_PERM: begin
        s_d   = round_s;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == LAST_RND) begin
          rnd_d   = 4'd0;
          state_d = AD_WAIT;
        end
      end
      CT_PERM: begin
        s_d   = round_s;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == LAST_RND) begin
          rnd_d   = PA_START;
          state_d = CT_WAIT;
          if (last_q) begin
            s_d[0]  = round_s[0] ^ 64'h8000000000000000;
            s_d[1]  = round_s[1] ^ key_q[127:64];
            s_d[2]  = round_s[2] ^ key_q[63:0];
            state_d = FINAL;
          end
        end
      end
      FINAL: begin
        s_d   = round_s;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == LAST_RND) begin
          tag_ok_d = (({round_s[3], round_s[4]} ^ key_q) == tag_q);
          rnd_d    = 4'd0;
          state_d  = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == AD_WAIT) || (state_d == CT_WAIT);
    busy_d  = (state_d != IDLE) && (state_d != DONE);
    done_d  = (state_d == DONE);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      s_q           <= '0;
      rnd_q         <= 4'd0;
      key_q         <= 128'd0;
      tag_q         <= 128'd0;
      last_q        <= 1'b0;
      plain_q       <= 64'd0;
      plain_valid_q <= 1'b0;
      tag_ok_q      <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      s_q           <= s_d;
      rnd_q         <= rnd_d;
      key_q         <= key_d;
      tag_q         <= tag_d;
      last_q        <= last_d;
      plain_q       <= plain_d;
      plain_valid_q <= plain_valid_d;
      tag_ok_q      <= tag_ok_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      ready_q       <= ready_d;
    end
  end

  assign bus.data_ready_o  = ready_q;
  assign bus.plain_o       = plain_q;
  assign bus.plain_valid_o = plain_valid_q;
  assign bus.tag_ok_o      = tag_ok_q;
  assign bus.done_o        = done_q;
  assign bus.busy_o        = busy_q;

endmodule

// File: tb/tb_ascon_decrypt_core.sv
// Self-checking bench: a table-driven ASCON-128 encrypt model produces ciphertext
// and tag, the core decrypts them and plaintext, timing and tag result are checked.
module tb_ascon_decrypt_core;
  logic clk;
  logic rst;
  ascon_decrypt_core_if bus ();

  ascon_decrypt_core dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int pulses = 0;

  // S-box as a lookup on 5-bit columns, row 0 being the most significant bit.
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  logic [63:0]  ms [5];
  logic [63:0]  ad_a [8];
  logic [63:0]  pt_a [8];
  logic [63:0]  ct_a [8];
  logic [127:0] tag_m;

  always @(negedge clk) if (bus.plain_valid_o === 1'b1) pulses++;

  task automatic chk(input string nm, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  task automatic model_perm(input int nr);
    logic [63:0] n [5];
    logic [4:0]  col;
    logic [4:0]  o;
    for (int r = 12 - nr; r < 12; r++) begin
      ms[2] = ms[2] ^ 64'((15 - r) * 16 + r);
      for (int b = 0; b < 64; b++) begin
        col = {ms[0][b], ms[1][b], ms[2][b], ms[3][b], ms[4][b]};
        o = SBOX[col];
        n[0][b] = o[4]; n[1][b] = o[3]; n[2][b] = o[2]; n[3][b] = o[1]; n[4][b] = o[0];
      end
      ms[0] = n[0] ^ rotr(n[0], 19) ^ rotr(n[0], 28);
      ms[1] = n[1] ^ rotr(n[1], 61) ^ rotr(n[1], 39);
      ms[2] = n[2] ^ rotr(n[2], 1)  ^ rotr(n[2], 6);
      ms[3] = n[3] ^ rotr(n[3], 10) ^ rotr(n[3], 17);
      ms[4] = n[4] ^ rotr(n[4], 7)  ^ rotr(n[4], 41);
    end
  endtask

  // Full-block ASCON-128 encryption of pt_a with ad_a; fills ct_a and tag_m.
  task automatic model_encrypt(input logic [127:0] key, input logic [127:0] nonce, input int nad, input int nct);
    ms[0] = 64'h80400c0600000000;
    ms[1] = key[127:64]; ms[2] = key[63:0];
    ms[3] = nonce[127:64]; ms[4] = nonce[63:0];
    model_perm(12);
    ms[3] = ms[3] ^ key[127:64]; ms[4] = ms[4] ^ key[63:0];
    for (int i = 0; i < nad; i++) begin
      ms[0] = ms[0] ^ ad_a[i];
      model_perm(6);
    end
    ms[4] = ms[4] ^ 64'd1;
    for (int i = 0; i < nct; i++) begin
      ms[0] = ms[0] ^ pt_a[i];
      ct_a[i] = ms[0];
      model_perm(6);
    end
    ms[0] = ms[0] ^ 64'h8000000000000000;
    ms[1] = ms[1] ^ key[127:64]; ms[2] = ms[2] ^ key[63:0];
    model_perm(12);
    tag_m = {ms[3], ms[4]} ^ key;
  endtask

  task automatic gen(input int nad, input int nct);
    for (int i = 0; i < nad; i++) ad_a[i] = {$urandom, $urandom};
    for (int i = 0; i < nct; i++) pt_a[i] = {$urandom, $urandom};
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (bus.data_ready_o !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.data_ready_o !== 1'b1) chk("ready_timeout", 128'd0, 128'd1);
  endtask

  task automatic run_msg(input logic [127:0] key, input logic [127:0] nonce, input int nad, input int nct,
                         input bit flip, input bit gaps, input bit noisy, input bit abort);
    int  n;
    int  p0;
    bit  is_ad;
    bit  seen;
    model_encrypt(key, nonce, nad, nct);
    @(negedge clk);
    bus.key_i = key; bus.nonce_i = nonce;
    bus.tag_i = flip ? (tag_m ^ 128'd1) : tag_m;
    bus.start_i = 1'b1;
    p0 = pulses;
    @(negedge clk);
    bus.start_i = 1'b0;
    chk("busy_after_start", 128'(bus.busy_o), 128'd1);
    chk("done_cleared", 128'(bus.done_o), 128'd0);
    wait_ready(n);
    chk("ready_latency", 128'(n + 1), 128'd13);
    for (int i = 0; i < nad + nct; i++) begin
      is_ad = (i < nad);
      wait_ready(n);
      if (i > 0) chk("ready_after_block", 128'(n), 128'd5);
      if (gaps) repeat ($urandom_range(0, 2)) begin
        bus.data_valid_i = 1'b0;
        @(negedge clk);
      end
      bus.data_valid_i = 1'b1;
      bus.data_i = is_ad ? ad_a[i] : ct_a[i - nad];
      bus.ad_i = is_ad;
      bus.last_i = !is_ad && (i == nad + nct - 1);
      @(negedge clk);
      if (noisy) begin
        bus.data_i = {$urandom, $urandom};
        bus.ad_i = 1'($urandom);
        bus.last_i = 1'($urandom);
        bus.start_i = 1'b1;
      end else begin
        bus.data_valid_i = 1'b0;
      end
      chk("pvalid_pulse", 128'(bus.plain_valid_o), 128'(!is_ad));
      if (!is_ad) chk("plain", 128'(bus.plain_o), 128'(pt_a[i - nad]));
      @(negedge clk);
      bus.start_i = 1'b0;
      chk("pvalid_single", 128'(bus.plain_valid_o), 128'd0);
      chk("ready_low_perm", 128'(bus.data_ready_o), 128'd0);
    end
    if (abort) begin
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_done", 128'(bus.done_o), 128'd0);
      chk("abort_busy", 128'(bus.busy_o), 128'd0);
      chk("abort_plain", 128'(bus.plain_o), 128'd0);
      chk("abort_tag_ok", 128'(bus.tag_ok_o), 128'd0);
      rst = 1'b0;
      bus.data_valid_i = 1'b0;
      seen = 1'b0;
      repeat (25) begin
        @(negedge clk);
        if (bus.done_o !== 1'b0) seen = 1'b1;
      end
      chk("abort_no_done", 128'(seen), 128'd0);
    end else begin
      repeat (16) @(negedge clk);
      chk("done_early", 128'(bus.done_o), 128'd0);
      @(negedge clk);
      bus.data_valid_i = 1'b0;
      chk("done_latency", 128'(bus.done_o), 128'd1);
      chk("busy_in_done", 128'(bus.busy_o), 128'd0);
      chk("tag_ok", 128'(bus.tag_ok_o), 128'(!flip));
      chk("pulse_count", 128'(pulses - p0), 128'(nct));
      repeat (3) @(negedge clk);
      chk("done_held", 128'(bus.done_o), 128'd1);
      chk("plain_held", 128'(bus.plain_o), 128'(pt_a[nct - 1]));
    end
  endtask

  initial begin
    logic [127:0] k;
    logic [127:0] rk;
    logic [127:0] rn;
    int nad;
    int nct;
    k = 128'h000102030405060708090a0b0c0d0e0f;
    rst = 1'b1;
    bus.start_i = 1'b0; bus.key_i = 128'd0; bus.nonce_i = 128'd0; bus.tag_i = 128'd0;
    bus.data_i = 64'd0; bus.data_valid_i = 1'b0; bus.ad_i = 1'b0; bus.last_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 128'(bus.data_ready_o), 128'd0);
    chk("rst_busy", 128'(bus.busy_o), 128'd0);
    chk("rst_done", 128'(bus.done_o), 128'd0);
    chk("rst_pvalid", 128'(bus.plain_valid_o), 128'd0);
    chk("rst_plain", 128'(bus.plain_o), 128'd0);
    chk("rst_tag_ok", 128'(bus.tag_ok_o), 128'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", 128'(bus.busy_o), 128'd0);
    chk("idle_ready", 128'(bus.data_ready_o), 128'd0);

    gen(0, 1);
    run_msg(k, k, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    gen(2, 3);
    run_msg(k, k, 2, 3, 1'b0, 1'b1, 1'b0, 1'b0);
    run_msg(k, k, 2, 3, 1'b1, 1'b1, 1'b0, 1'b0);
    run_msg(k, k, 2, 3, 1'b0, 1'b0, 1'b0, 1'b1);
    run_msg(k, k, 2, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    run_msg(k, k, 2, 3, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int it = 0; it < 3; it++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rn = {$urandom, $urandom, $urandom, $urandom};
      nad = $urandom_range(0, 3);
      nct = $urandom_range(1, 4);
      gen(nad, nct);
      run_msg(rk, rn, nad, nct, 1'($urandom), 1'b1, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/ascon_decrypt_core.md
Name: ascon_decrypt_core

Overview:
- Self-sequencing ASCON-128 authenticated-decryption engine; the receive-side counterpart of the encryption permutation datapath.
- Owns its state register, round counter and phase FSM, and reuses the team's Pc / substitution / Pl round layers, one round per cycle.
- Accepts associated-data and ciphertext blocks over a valid/ready stream and emits plaintext blocks.
- Recomputes the tag and reports pass/fail against the expected tag.

Parameters:
- PA, 12, rounds of initialisation/finalisation permutation
- PB, 6, rounds of the intermediate permutation
- IV, 64'h80400c0600000000, ASCON-128 initial value

Ports:
- clock_i  in  1  system clock
- reset_i  in  1  asynchronous, active-high reset
- start_i  in  1  start pulse, sampled only in IDLE
- key_i  in  128  key; sampled with start_i and held internally
- nonce_i  in  128  nonce; sampled with start_i
- tag_i  in  128  expected tag; sampled with start_i
- data_i  in  64  AD or ciphertext block; always full 64 bits, AD already padded by sender
- data_valid_i  in  1  data_i valid
- ad_i  in  1  1 = block is associated data, 0 = ciphertext
- last_i  in  1  final ciphertext block; ignored when ad_i=1
- data_ready_o  out  1  core can accept a block
- plain_o  out  64  decrypted block
- plain_valid_o  out  1  one-cycle pulse qualifying plain_o
- tag_ok_o  out  1  tag comparison result, valid while done_o high
- done_o  out  1  high in DONE
- busy_o  out  1  high in any state except IDLE and DONE

Behaviour:
- Reset (async, any state): FSM to IDLE. State, round counter, key/tag copies, plain_o, plain_valid_o, tag_ok_o and done_o all clear to 0.
- Round constant for round index r (0..11): ((15-r)<<4)|r, XORed into S2. PA runs r=0..11; PB runs r=6..11.
- States: IDLE, INIT, AD_WAIT, AD_PERM, CT_WAIT, CT_PERM, FINAL, DONE.
- IDLE / DONE + start_i: load S = {IV, K, N} (S0=IV, S1||S2=K, S3||S4=N), capture key/tag, go INIT with counter=0. A start_i in DONE clears done_o. start_i in other states is ignored.
- INIT: PA rounds. On the 12th round, the registered value is round output XOR {0,0,0,K[127:64],K[63:0]}. Then go to AD_WAIT.
- data_ready_o = 1 exactly in AD_WAIT and CT_WAIT. A transfer occurs when data_valid_i & data_ready_o.
- AD_WAIT, transfer with ad_i=1: S0 ^= data_i, go AD_PERM for PB rounds, then return to AD_WAIT.
- AD_WAIT, transfer with ad_i=0: domain separation (S4 ^= 1) and ciphertext processing in the same cycle.
- Ciphertext transfer (in AD_WAIT with ad_i=0, or in CT_WAIT with any ad_i):
  - plain_o <= S0 ^ data_i and S0 <= data_i.
  - plain_valid_o pulses on the next cycle.
  - go CT_PERM.
- CT_WAIT treats every block as ciphertext.
- No output backpressure: the consumer must take plain_o on the pulse. plain_o holds its value until the next block.
- CT_PERM: PB rounds.
  - Block not last: return to CT_WAIT.
  - Block last: the 6th round's registered value gets S0 ^= 64'h8000000000000000 (empty final padding block) and S1||S2 ^= K. Then go FINAL.
- FINAL: PA rounds. On the 12th round compute T = (S3||S4 of round output) ^ K, tag_ok_o <= (T == captured tag), go DONE.
- DONE: done_o=1; tag_ok_o and plain_o held until the next start_i or reset.
- Latency: start edge at cycle 0 gives data_ready_o high at cycle 13. Each block then takes 1 accept cycle + 6 permutation cycles before ready returns (ready high 7 cycles after acceptance). From the last-block accept, done_o rises 19 cycles later.
- At least one ciphertext block per message; zero AD blocks allowed (first block with ad_i=0).
- Reset asserted mid-message aborts it with no done_o. The next start_i begins a fresh message.

Test Plan:
- Reset then idle → all outputs 0, data_ready_o=0; start_i at cycle 0 → busy_o=1 from cycle 1, data_ready_o=1 at cycle 13.
- K=N=000102..0F, no AD, one ciphertext block and tag from the golden ASCON-128 encrypt model, last_i=1 → plain_o matches the model plaintext (plain_valid_o pulses once), done_o 19 cycles after accept, tag_ok_o=1.
- Same key/nonce, two AD blocks + three ciphertext blocks (model vectors), data_valid_i with gaps → three plain_valid_o pulses in order with model values, tag_ok_o=1.
- Repeat the previous vector with tag_i bit 0 flipped → identical plaintexts, tag_ok_o=0, done_o=1.
- Reset pulsed during the 4th FINAL round → outputs cleared, no done_o; a new start with vector 2 passes.
- data_valid_i held high during the PERM states and start_i pulsed while busy → no extra transfers, sequence unaffected, result matches vector 2.
